// File: rtl/bcd_sum_accumulator_if.sv
// Digit handshake between the excess-3 decoder and the BCD accumulator.
// The decoder drives valid/digit; the accumulator answers with ready.
interface bcd_sum_accumulator_if;
  logic       in_valid;
  logic [3:0] in_digit;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_digit,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_digit,
    output in_ready
  );
endinterface

// File: rtl/bcd_sum_accumulator.sv
// Four-digit packed-BCD running total, one decimal position per clock.
// Reports a done pulse plus sticky overflow and bad-digit status.
module bcd_sum_accumulator (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  bcd_sum_accumulator_if.slave        in_if,
  output logic [15:0]                 sum,
  output logic                        done,
  output logic                        overflow,
  output logic                        bad_digit
);

  typedef enum logic {
    IDLE,
    ADD
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  pos_q, pos_d;
  logic [3:0]  a_q, a_d;
  logic [15:0] sum_q, sum_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        bad_q, bad_d;

  logic        xfer;
  logic [3:0]  cur;
  logic [4:0]  t;
  logic        carry;
  logic [3:0]  nd;

  assign in_if.in_ready = (state_q == IDLE) && !clear;
  assign xfer = in_if.in_valid && in_if.in_ready;

  // Single digit slice of the total selected by the ripple position
  assign cur   = sum_q[{pos_q, 2'b00} +: 4];
  assign t     = {1'b0, cur} + {1'b0, a_q};
  assign carry = t > 5'd9;
  assign nd    = carry ? 4'(t - 5'd10) : t[3:0];

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    a_d     = a_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    if (clear) begin
      state_d = IDLE;
      pos_d   = 2'd0;
      a_d     = 4'd0;
      sum_d   = 16'h0000;
      ovf_d   = 1'b0;
      bad_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            if (in_if.in_digit <= 4'd9) begin
              a_d     = in_if.in_digit;
              pos_d   = 2'd0;
              state_d = ADD;
            end else begin
              bad_d = 1'b1;
            end
          end
        end
        ADD: begin
          sum_d[{pos_q, 2'b00} +: 4] = nd;
          a_d   = {3'b000, carry};
          pos_d = pos_q + 2'd1;
          // Fixed four-step latency: the last position decides overflow
          if (pos_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (carry) ovf_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= 2'd0;
      a_q     <= 4'd0;
      sum_q   <= 16'h0000;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      a_q     <= a_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign sum       = sum_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign bad_digit = bad_q;

endmodule

// File: tb/tb_bcd_sum_accumulator.sv
// Scoreboard bench for bcd_sum_accumulator: decimal reference model,
// directed corner cases plus randomized digit/idle/clear traffic.
module tb_bcd_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] sum;
  logic        done;
  logic        overflow;
  logic        bad_digit;

  bcd_sum_accumulator_if bus();

  bcd_sum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_if     (bus.slave),
    .sum       (sum),
    .done      (done),
    .overflow  (overflow),
    .bad_digit (bad_digit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: plain decimal total and sticky flags
  int total_m  = 0;
  bit ovf_m    = 1'b0;
  bit bad_m    = 1'b0;
  int busy_end = 0;

  typedef struct {
    int total;
    bit ovf;
    bit bad;
    int due;
  } exp_t;

  exp_t sb[$];

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    total_m  = 0;
    ovf_m    = 1'b0;
    bad_m    = 1'b0;
    busy_end = 0;
    sb.delete();
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    check("in_ready", 32'(bus.in_ready),
          32'(!clear && (cyc >= busy_end)));
    if (cyc >= busy_end) begin
      check("idle_sum", 32'(sum), 32'(to_bcd(total_m)));
      check("idle_overflow", 32'(overflow), 32'(ovf_m));
      check("idle_bad_digit", 32'(bad_digit), 32'(bad_m));
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("done_sum", 32'(sum), 32'(to_bcd(e.total)));
        check("done_overflow", 32'(overflow), 32'(e.ovf));
        check("done_bad_digit", 32'(bad_digit), 32'(e.bad));
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      check("done_missing", 32'(done), 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic step(bit v, logic [3:0] d, bit clr, output bit took);
    @(negedge clk);
    #1;
    bus.in_valid = v;
    bus.in_digit = d;
    clear        = clr;
    took         = 1'b0;
    if (clr) begin
      model_reset();
    end else if (v && rst_n && cyc >= busy_end) begin
      took = 1'b1;
      if (int'(d) <= 9) begin
        total_m += int'(d);
        if (total_m > 9999) begin
          total_m -= 10000;
          ovf_m = 1'b1;
        end
        busy_end = cyc + 5;
        sb.push_back('{total_m, ovf_m, bad_m, cyc + 5});
      end else begin
        bad_m = 1'b1;
      end
    end
  endtask

  task automatic idle(int n);
    bit t;
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, t);
  endtask

  task automatic do_clear();
    bit t;
    step(1'b0, 4'd0, 1'b1, t);
    step(1'b0, 4'd0, 1'b0, t);
  endtask

  task automatic send(logic [3:0] d);
    bit t;
    int n;
    t = 1'b0;
    n = 0;
    while (!t && n < 20) begin
      step(1'b1, d, 1'b0, t);
      n++;
    end
    if (!t) check("send_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    bus.in_valid = 1'b0;
    bus.in_digit = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_sum", 32'(sum), 32'h0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_bad", 32'(bad_digit), 32'd0);
    #1 rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Back-to-back 5, 7, 9 with valid held high
    send(4'd5);
    send(4'd7);
    send(4'd9);
    idle(6);
    check("sum_0021", 32'(sum), 32'h0021);

    // 0999 + 1 ripples across three positions
    do_clear();
    for (int i = 0; i < 111; i++) send(4'd9);
    idle(5);
    check("sum_0999", 32'(sum), 32'h0999);
    send(4'd1);
    idle(6);
    check("sum_1000", 32'(sum), 32'h1000);
    check("ovf_1000", 32'(overflow), 32'd0);

    // 9999 + 1 wraps and sets overflow, which stays sticky
    do_clear();
    for (int i = 0; i < 1111; i++) send(4'd9);
    idle(5);
    check("sum_9999", 32'(sum), 32'h9999);
    send(4'd1);
    idle(6);
    check("sum_wrap", 32'(sum), 32'h0000);
    check("ovf_wrap", 32'(overflow), 32'd1);
    send(4'd3);
    idle(6);
    check("sum_0003", 32'(sum), 32'h0003);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Illegal digit is dropped, flagged, and does not stall the port
    send(4'hC);
    step(1'b0, 4'd0, 1'b0, t);
    check("bad_set", 32'(bad_digit), 32'd1);
    check("bad_ready", 32'(bus.in_ready), 32'd1);
    check("bad_no_done", 32'(done), 32'd0);
    check("bad_sum", 32'(sum), 32'h0003);
    send(4'd2);
    idle(6);
    check("sum_0005", 32'(sum), 32'h0005);

    // Clear at E2 of 0009 + 9 aborts the add without a done pulse
    do_clear();
    send(4'd9);
    idle(5);
    send(4'd9);
    step(1'b0, 4'd0, 1'b0, t);
    step(1'b0, 4'd0, 1'b1, t);
    #1 check("ready_during_clear", 32'(bus.in_ready), 32'd0);
    step(1'b0, 4'd0, 1'b0, t);
    #1 check("ready_after_clear", 32'(bus.in_ready), 32'd1);
    check("clear_sum", 32'(sum), 32'h0000);
    check("clear_ovf", 32'(overflow), 32'd0);
    check("clear_bad", 32'(bad_digit), 32'd0);
    idle(6);

    // Randomized digits (some illegal), idle gaps and occasional clears
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) do_clear();
      else if (r < 30) idle($urandom_range(1, 4));
      else send(4'($urandom_range(0, 15)));
    end
    idle(6);

    // Asynchronous reset in the middle of an add
    send(4'd7);
    step(1'b0, 4'd0, 1'b0, t);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sum", 32'(sum), 32'h0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_bad", 32'(bad_digit), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    send(4'd4);
    idle(6);
    check("sum_after_arst", 32'(sum), 32'h0004);

    idle(4);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_sum_accumulator.md
# bcd_sum_accumulator

Running-total stage downstream of the excess-3-to-BCD decoder. It consumes one decoded BCD digit at a time through a valid/ready handshake and adds it into a 4-digit packed-BCD accumulator (0000–9999). The addition ripples one decimal position per clock. The block reports completion, sticky overflow, and sticky invalid-digit status to the control/display logic.

## Interface
Parameters:
- none; width fixed at 4 BCD digits (16 bits).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear of total and status; highest priority.
- in_valid  input  1  in_digit holds a digit to accumulate.
- in_digit  input  4  BCD digit from the decoder; legal values 0–9.
- in_ready  output  1  block can accept a digit this cycle.
- sum  output  16  packed BCD total; sum[3:0] is units, sum[15:12] is thousands.
- done  output  1  one-cycle pulse when an accepted digit is fully added.
- overflow  output  1  sticky: total wrapped past 9999.
- bad_digit  output  1  sticky: a digit 10–15 was presented and dropped.

## Operation
- States: IDLE, ADD. Position counter pos (2 bits), carry/addend register a (4 bits), captured digit register.
- in_ready = (state==IDLE) && !clear. It is combinational from state and clear.
- Transfer occurs when in_valid && in_ready at a rising edge.
- IDLE, transfer with in_digit <= 9: latch a = in_digit, pos = 0, go to ADD.
- IDLE, transfer with in_digit >= 10: set bad_digit, stay in IDLE, leave sum unchanged. No done pulse. The digit is consumed and dropped.
- ADD, each cycle: t = sum digit[pos] + a, 5-bit.
  - If t > 9: digit[pos] = t − 10, a = 1.
  - Else: digit[pos] = t, a = 0.
  - pos increments.
- ADD always runs exactly 4 cycles (pos 0..3), even when a becomes 0 early. Latency is fixed.
- End of ADD with pos==3:
  - If a carry results, set overflow. sum wraps modulo 10000 (9999 + 1 gives 0000).
  - Return to IDLE and assert done for the next cycle.
- in_valid during ADD is ignored: in_ready is low, so there is no transfer. The upstream stage holds the digit.
- clear=1 at an edge, in any state:
  - sum = 0, overflow = 0, bad_digit = 0, a = 0, pos = 0, state = IDLE, done = 0.
  - Any ADD in progress is aborted with no done pulse.
  - in_valid in that cycle is not accepted.
- Every stored BCD digit stays within 0–9 at all times.

## Timing
- Reset values (rst_n low, asynchronous): state = IDLE, sum = 16'h0000, done = 0, overflow = 0, bad_digit = 0, pos = 0, a = 0.
- in_ready is 1 immediately after reset deassertion, unless clear is high.
- Transfer at edge E0 leads to ADD of positions 0, 1, 2, 3 at edges E1..E4.
  - sum position k is final after edge E(k+1).
  - At E4: state becomes IDLE, done = 1 for the cycle E4–E5, in_ready high again in the same cycle.
- Peak throughput is one digit every 5 cycles. A new transfer may occur at E5, while done is high.
- done is a registered single-cycle pulse. It never asserts for a dropped bad digit or an aborted add.
- overflow and bad_digit set at the edge where the condition is detected. Only clear or rst_n removes them.
- rst_n asserted mid-ADD: all state returns to reset values immediately. The partial sum is discarded.

## Test plan
- Reset, then feed digits 5, 7, 9 back-to-back with in_valid held high.
  - Expect in_ready pattern 1,0,0,0,0,1 per digit.
  - Expect done 5 cycles after each transfer edge.
  - Expect sum 0005, then 0012, then 0021.
- Preload to 0999 via digit stream (111 × 9), then add 1.
  - Carry ripples across 3 positions; sum = 1000 after E4.
  - done pulses once; overflow = 0.
- Reach 9999, add 1: sum = 0000, overflow = 1, done = 1. Add 3: sum = 0003, overflow still 1.
- Present in_digit = 4'hC in IDLE: bad_digit = 1, no done, sum unchanged, in_ready remains 1. A following digit 2 accumulates normally.
- Assert clear at E2 of an ADD from 0009 + 9. Expect sum = 0000, overflow = 0, bad_digit = 0, no done pulse, state IDLE. Check that in_ready is 0 during clear and 1 the cycle after.
- Assert rst_n low asynchronously mid-cycle during ADD. Outputs reach reset values before the next clock edge. After release, the first transfer works normally.
